universal_shift_reg: RTL

//   Parametrised universal shift register. Successor to the 8-bit

---
 rtl/universal_shift_reg_if.sv | 26 ++
 rtl/universal_shift_reg.sv | 120 ++++++++++++
 2 files changed

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for the universal shift register: mode, load/serial inputs,
// burst request, and the register/status outputs.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output mode, load_data, ser_in, start, count,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  mode, load_data, ser_in, start, count,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register with direct modes and a counted burst
// engine (IDLE/BURST) that repeats one latched shift/rotate N times.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  universal_shift_reg_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_ser_out, w_ser_out_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_mode, w_mode_nxt;
  logic [WIDTH:0]   w_op_res;
  logic [2:0]       w_op_sel;

  // Returns {ser_out, q} after one application of op; ser_out is kept for non-shifting ops.
  function automatic logic [WIDTH:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ld,
    input logic             si,
    input logic             so
  );
    case (op)
      M_SHR:   return {d[0], si, d[WIDTH-1:1]};
      M_SHL:   return {d[WIDTH-1], d[WIDTH-2:0], si};
      M_LOAD:  return {so, ld};
      M_ROR:   return {d[0], d[0], d[WIDTH-1:1]};
      M_ROL:   return {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      M_ASR:   return {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      M_CLEAR: return {so, {WIDTH{1'b0}}};
      default: return {so, d};
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
           (op == M_ROL) || (op == M_ASR);
  endfunction

  assign w_op_sel = (r_state == BURST) ? r_mode : bus.mode;
  assign w_op_res = apply_op(w_op_sel, r_q, bus.load_data, bus.ser_in, r_ser_out);

  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_ser_out_nxt = r_ser_out;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_mode_nxt    = r_mode;
    case (r_state)
      IDLE: begin
        if (bus.start && is_shift(bus.mode) && (bus.count != '0)) begin
          // Burst accepted: q is untouched on the accepting edge.
          w_mode_nxt  = bus.mode;
          w_cnt_nxt   = bus.count;
          w_busy_nxt  = 1'b1;
          w_state_nxt = BURST;
        end else begin
          {w_ser_out_nxt, w_q_nxt} = w_op_res;
          w_done_nxt = bus.start;
        end
      end
      BURST: begin
        {w_ser_out_nxt, w_q_nxt} = w_op_res;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_ser_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= M_HOLD;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_ser_out <= w_ser_out_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mode    <= w_mode_nxt;
    end
  end

  assign bus.q       = r_q;
  assign bus.ser_out = r_ser_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
